// File: rtl/upuart_pkg.sv
// ---------------------------------------------------------------------------
// upuart_pkg
// Shared constants and types for the UART subsystem.
//   UPUART_FIFO_WIDTH     : default byte width of the TX/RX data paths
//   UPUART_TX_ARB_TMO_DEF : default idle timeout of the TX write-port arbiter
//   upuart_arb_state_e    : arbiter state encoding (IDLE / OWN)
// ---------------------------------------------------------------------------
package upuart_pkg;

  localparam int UPUART_FIFO_WIDTH     = 8;
  localparam int UPUART_TX_ARB_TMO_DEF = 1024;

  typedef enum logic {
    UPUART_ARB_IDLE = 1'b0,
    UPUART_ARB_OWN  = 1'b1
  } upuart_arb_state_e;

endpackage : upuart_pkg

// File: rtl/upuart_rr_pick.sv
// ---------------------------------------------------------------------------
// upuart_rr_pick
// Combinational rotate-priority picker. Returns the first set bit of req,
// searching upward from ptr with wrap-around, as a one-hot vector (zero when
// no request is set). Shared by the TX arbiter and the RX-side demux.
// Ports:
//   req : request vector, one bit per requester
//   ptr : index where the search starts (must be < NREQ)
//   gnt : one-hot winner, or all zeros
// ---------------------------------------------------------------------------
module upuart_rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;

  // For every search offset exactly one position k matches, so the inner
  // index stays a constant after unrolling and the first hit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[k] && (k == (int'(ptr) + off) % NREQ)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule : upuart_rr_pick

// File: rtl/upuart_tx_arb.sv
// ---------------------------------------------------------------------------
// upuart_tx_arb
// Message-granular round-robin arbiter sharing the TX FIFO write port between
// NREQ byte-stream requesters. A granted requester owns the port until it
// writes a byte flagged last, or until it has been idle for TIMEOUT cycles,
// so messages never interleave. One idle (arbitration) cycle between owners.
//
// Optional feature (macro UPUART_TX_ARB_PRIO0_EN): requester 0 wins every
// arbitration it takes part in, and its release leaves the round-robin
// pointer untouched. It never pre-empts an owned message.
//
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   i_req      : per-requester byte valid
//   i_data     : per-requester byte, requester k at [k*FIFO_WIDTH +: FIFO_WIDTH]
//   i_last     : byte is the last of its message
//   o_ack      : byte accepted this cycle (one-hot or zero)
//   o_grant    : registered one-hot owner
//   o_busy     : grant held
//   o_tmo      : one-cycle pulse when a grant is revoked by timeout
//   fifo_full  : TX FIFO full
//   fifo_data  : byte to the TX FIFO
//   fifo_wr    : TX FIFO write strobe
// ---------------------------------------------------------------------------
module upuart_tx_arb
  import upuart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FIFO_WIDTH = UPUART_FIFO_WIDTH,
  parameter int TMO_WIDTH  = 16,
  parameter int TIMEOUT    = UPUART_TX_ARB_TMO_DEF
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*FIFO_WIDTH-1:0] i_data,
  input  logic [NREQ-1:0]            i_last,
  output logic [NREQ-1:0]            o_ack,
  output logic [NREQ-1:0]            o_grant,
  output logic                       o_busy,
  output logic                       o_tmo,
  input  logic                       fifo_full,
  output logic [FIFO_WIDTH-1:0]      fifo_data,
  output logic                       fifo_wr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  upuart_arb_state_e     state_q, state_d;
  logic [NREQ-1:0]       grant_d, rr_gnt, pick;
  logic [PW-1:0]         owner_q, owner_d, ptr_q, ptr_d, pick_idx, ptr_rel;
  logic                  req_g, last_g, own, rel_last, tmo_fire;
  logic [FIFO_WIDTH-1:0] data_g;

  upuart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

`ifdef UPUART_TX_ARB_PRIO0_EN
  assign pick = i_req[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_gnt;
`else
  assign pick = rr_gnt;
`endif

  // One-hot to index for the new owner, and the owner's request/last/byte.
  always_comb begin
    pick_idx = '0;
    req_g    = 1'b0;
    last_g   = 1'b0;
    data_g   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) pick_idx = PW'(k);
      if (owner_q == PW'(k)) begin
        req_g  = i_req[k];
        last_g = i_last[k];
        data_g = i_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  assign own       = (state_q == UPUART_ARB_OWN);
  assign o_busy    = own;
  assign fifo_wr   = own & req_g & ~fifo_full;
  assign fifo_data = own ? data_g : '0;
  assign o_ack     = {NREQ{fifo_wr}} & o_grant;
  assign rel_last  = fifo_wr & last_g;

  // Pointer after a release: one past the owner, wrapping at NREQ.
  always_comb begin
    ptr_rel = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;
`ifdef UPUART_TX_ARB_PRIO0_EN
    if (owner_q == '0) ptr_rel = ptr_q;
`endif
  end

  // Idle counter: cleared outside OWN and on every write, frozen while the
  // FIFO is full (backpressure is not idleness), saturating at TIMEOUT-1.
  if (TIMEOUT > 0) begin : g_tmo
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT - 1);
    logic [TMO_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                                 cnt_q <= '0;
      else if (!own || fifo_wr)                  cnt_q <= '0;
      else if (!fifo_full && cnt_q != TMO_LAST)  cnt_q <= cnt_q + 1'b1;
    end

    assign tmo_fire = own & ~req_g & ~fifo_full & (cnt_q == TMO_LAST);
  end else begin : g_no_tmo
    assign tmo_fire = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = o_grant;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      UPUART_ARB_IDLE: begin
        if (|i_req) begin
          state_d = UPUART_ARB_OWN;
          grant_d = pick;
          owner_d = pick_idx;
        end
      end
      UPUART_ARB_OWN: begin
        if (rel_last || tmo_fire) begin
          state_d = UPUART_ARB_IDLE;
          grant_d = '0;
          ptr_d   = ptr_rel;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= UPUART_ARB_IDLE;
      o_grant <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      o_tmo   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_grant <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      o_tmo   <= tmo_fire;
    end
  end

endmodule : upuart_tx_arb
